scr1_pipe_mprf_mp: RTL

SCR1_PIPE_MPRF_MP -- requirements
Module: scr1_pipe_mprf_mp

---
 rtl/scr1_pipe_mprf_mp.sv | 120 ++++++++++++
 1 files changed

// File: rtl/scr1_pipe_mprf_mp.sv
// Multi-ported integer register file: NRD read / NWR write ports, x0 hardwired to zero,
// self-zeroing INIT sweep after reset or soft clear, optional registered (write-first) reads.
module scr1_pipe_mprf_mp #(
   parameter int XLEN   = 32,
   parameter int AWIDTH = 5,
   parameter int NRD    = 2,
   parameter int NWR    = 2,
   parameter int RD_LAT = 1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        clr_req_i,
   output logic                        ready_o,
   input  logic [NRD-1:0][AWIDTH-1:0]  rd_addr_i,
   output logic [NRD-1:0][XLEN-1:0]    rd_data_o,
   input  logic [NWR-1:0]              wr_req_i,
   input  logic [NWR-1:0][AWIDTH-1:0]  wr_addr_i,
   input  logic [NWR-1:0][XLEN-1:0]    wr_data_i
);

   localparam int DEPTH = 2**AWIDTH;
   localparam logic [0:0] ST_INIT  = 1'b0;
   localparam logic [0:0] ST_READY = 1'b1;
   localparam logic [AWIDTH-1:0] CNT_FIRST = AWIDTH'(1);
   localparam logic [AWIDTH-1:0] CNT_LAST  = AWIDTH'(DEPTH-1);

   logic [0:0]        state;
   logic [AWIDTH-1:0] cnt;
   logic [NWR-1:0]    wr_en;
   logic [XLEN-1:0]   mem [DEPTH];

   assign ready_o = (state == ST_READY);

   // Counter is parked at 1 while READY so a clear only has to flip the state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_INIT;
         cnt   <= CNT_FIRST;
      end else if (state == ST_INIT) begin
         if (cnt == CNT_LAST) begin
            state <= ST_READY;
            cnt   <= CNT_FIRST;
         end else begin
            cnt <= cnt + AWIDTH'(1);
         end
      end else if (clr_req_i) begin
         state <= ST_INIT;
         cnt   <= CNT_FIRST;
      end
   end

   always_comb begin
      for (int k = 0; k < NWR; k++)
         wr_en[k] = ready_o && wr_req_i[k] && (wr_addr_i[k] != '0);
   end

   // No reset on the array; later ports are assigned last, so port NWR-1 wins collisions.
   always_ff @(posedge clk) begin
      if (!ready_o) begin
         mem[cnt] <= '0;
      end else begin
         for (int k = 0; k < NWR; k++)
            if (wr_en[k]) mem[wr_addr_i[k]] <= wr_data_i[k];
      end
   end

   for (genvar i = 0; i < NRD; i++) begin : g_rd
      if (RD_LAT == 0) begin : g_async
         assign rd_data_o[i] = (ready_o && (rd_addr_i[i] != '0)) ? mem[rd_addr_i[i]] : '0;
      end else begin : g_sync
         logic            fwd_hit;
         logic [XLEN-1:0] fwd_data;
         logic            vld_q;
         logic [XLEN-1:0] raw_q;

         always_comb begin
            fwd_hit  = 1'b0;
            fwd_data = '0;
            for (int k = 0; k < NWR; k++) begin
               if (wr_en[k] && (wr_addr_i[k] == rd_addr_i[i])) begin
                  fwd_hit  = 1'b1;
                  fwd_data = wr_data_i[k];
               end
            end
         end

         // Zero/ready qualifier travels with the data so x0 and INIT reads stay zero.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               vld_q <= 1'b0;
               raw_q <= '0;
            end else begin
               vld_q <= ready_o && (rd_addr_i[i] != '0);
               raw_q <= fwd_hit ? fwd_data : mem[rd_addr_i[i]];
            end
         end

         assign rd_data_o[i] = vld_q ? raw_q : '0;
      end
   end

`ifdef SCR1_TRGT_SIMULATION
   if (NRD < 1 || NRD > 4) begin : g_bad_nrd
      $error("scr1_pipe_mprf_mp: NRD out of range 1..4");
   end
   if (NWR < 1 || NWR > 2) begin : g_bad_nwr
      $error("scr1_pipe_mprf_mp: NWR out of range 1..2");
   end
   for (genvar k = 0; k < NWR; k++) begin : g_wr_chk
      always @(posedge clk) begin
         if (!rst && ready_o && wr_req_i[k] === 1'b1) begin
            assert (!$isunknown(wr_addr_i[k])) else $error("X on wr_addr_i[%0d]", k);
            if (wr_addr_i[k] != '0)
               assert (!$isunknown(wr_data_i[k])) else $error("X on wr_data_i[%0d]", k);
         end
      end
   end
`endif

endmodule
